repeat_nfa_branch_param: RTL and testbench

// - Parametrised NFA branch: a chain of up to DEPTH single-character stages matching a runtime-programmable literal.
// - Each stage may be marked repeat (char+).
// - Adds payload stall, pattern config port, a registered match pulse and a saturating match counter.
// - Sits where fixed-string branches sit: fed by the byte stream, its match feeds the rule OR-tree.

---
 rtl/repeat_nfa_branch_param_if.sv | 41 ++++
 rtl/repeat_nfa_branch_param.sv | 144 ++++++++++++++
 tb/tb_repeat_nfa_branch_param.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/repeat_nfa_branch_param_if.sv
// ----------------------------------------------------------------------------
// repeat_nfa_branch_param_if
// Groups the byte stream, pattern configuration and match reporting signals
// of one NFA branch.
//   master : stream/config source (drives en, payload*, cfg_*, cnt_clr)
//   slave  : the branch itself (drives match, active, match_count)
// Widths must match the parameters of the branch instance it connects to.
// ----------------------------------------------------------------------------
interface repeat_nfa_branch_param_if #(
    parameter int COUNT_W = 16,
    parameter int IDX_W   = 3,
    parameter int LEN_W   = 4
);
    logic               en;
    logic [7:0]         payload;
    logic               payload_valid;
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_idx;
    logic [7:0]         cfg_char;
    logic               cfg_rep;
    logic               cfg_len_we;
    logic [LEN_W-1:0]   cfg_len;
    logic               cnt_clr;
    logic               match;
    logic               active;
    logic [COUNT_W-1:0] match_count;

    modport master (
        output en, payload, payload_valid,
        output cfg_we, cfg_idx, cfg_char, cfg_rep, cfg_len_we, cfg_len,
        output cnt_clr,
        input  match, active, match_count
    );

    modport slave (
        input  en, payload, payload_valid,
        input  cfg_we, cfg_idx, cfg_char, cfg_rep, cfg_len_we, cfg_len,
        input  cnt_clr,
        output match, active, match_count
    );
endinterface

// File: rtl/repeat_nfa_branch_param.sv
// ----------------------------------------------------------------------------
// repeat_nfa_branch_param
// Parametrised NFA branch: a chain of up to DEPTH single-character stages
// matching a runtime-programmable literal, each stage optionally "char+".
// Completion raises a registered one-cycle match pulse, which also feeds a
// saturating match counter.
//
// Ports
//   clk      : clock, rising edge
//   reset_n  : asynchronous reset, active low
//   bus      : slave side of repeat_nfa_branch_param_if
//              en/payload/payload_valid   byte stream, valid low = stall
//              cfg_we/cfg_idx/cfg_char/cfg_rep   per-stage pattern write
//              cfg_len_we/cfg_len         active length (>DEPTH saturates,
//                                         0 disables the branch)
//              cnt_clr                    synchronous clear of match_count
//              match/active/match_count   results
//
// Stage state bits
//   s[i] | meaning
//   -----+--------------------------------------------------------------
//   0    | no partial match currently ends at stage i
//   1    | chars 0..i matched, ending on the most recent valid beat
// ----------------------------------------------------------------------------
module repeat_nfa_branch_param #(
    parameter int DEPTH   = 8,
    parameter int COUNT_W = 16,
    parameter int IDX_W   = 3,
    parameter int LEN_W   = 4
) (
    input logic                      clk,
    input logic                      reset_n,
    repeat_nfa_branch_param_if.slave bus
);

    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

    // pattern register file
    logic [7:0]       pat_char [DEPTH];
    logic [DEPTH-1:0] pat_rep;
    logic [LEN_W-1:0] pat_len;
    logic [LEN_W-1:0] len_wr;

    // matcher
    logic [DEPTH-1:0]   s;
    logic [DEPTH-1:0]   s_nxt;
    logic [DEPTH-1:0]   eq;
    logic [DEPTH-1:0]   prev;
    logic [DEPTH-1:0]   len_mask;
    logic [DEPTH-1:0]   last_mask;
    logic               match_nxt;
    logic               match_q;
    logic [COUNT_W-1:0] count_q;
    logic               cfg_any;

    assign cfg_any = bus.cfg_we | bus.cfg_len_we;
    assign len_wr  = (bus.cfg_len > DEPTH_LEN) ? DEPTH_LEN : bus.cfg_len;

    // ------------------------------------------------------------------
    // Pattern register file with index decode. Indices with no matching
    // stage simply hit no entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pat_char[i] <= 8'h00;
            end
            pat_char[0] <= 8'h61;
            pat_char[1] <= 8'h62;
            pat_char[2] <= 8'h63;
            pat_rep     <= '0;
            pat_len     <= LEN_W'(3);
        end else begin
            if (bus.cfg_we) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (bus.cfg_idx == IDX_W'(i)) begin
                        pat_char[i] <= bus.cfg_char;
                        pat_rep[i]  <= bus.cfg_rep;
                    end
                end
            end
            if (bus.cfg_len_we) begin
                pat_len <= len_wr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state of the stage chain. Stage i is fed by stage i-1 (stage 0
    // by en) or, when marked repeat, by itself. The final stage is picked
    // with a one-hot mask so that len=0 yields no match at all.
    // ------------------------------------------------------------------
    always_comb begin
        eq        = '0;
        len_mask  = '0;
        last_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            eq[i]        = (bus.payload == pat_char[i]);
            len_mask[i]  = (LEN_W'(i) < pat_len);
            last_mask[i] = (LEN_W'(i + 1) == pat_len);
        end
        prev      = {s[DEPTH-2:0], bus.en};
        s_nxt     = len_mask & eq & (prev | (pat_rep & s));
        match_nxt = |(s_nxt & last_mask);
    end

    // ------------------------------------------------------------------
    // Stage state and match pulse. A config write flushes everything in
    // flight because partial matches against the old pattern are
    // meaningless against the new one.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s       <= '0;
            match_q <= 1'b0;
        end else if (cfg_any) begin
            s       <= '0;
            match_q <= 1'b0;
        end else if (bus.payload_valid) begin
            s       <= s_nxt;
            match_q <= match_nxt;
        end else begin
            match_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Saturating match counter; clear wins over a coincident match.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (bus.cnt_clr) begin
            count_q <= '0;
        end else if (match_q && (count_q != {COUNT_W{1'b1}})) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    assign bus.match       = match_q;
    assign bus.active      = |s;
    assign bus.match_count = count_q;

endmodule

// File: tb/tb_repeat_nfa_branch_param.sv
// ----------------------------------------------------------------------------
// tb_repeat_nfa_branch_param
// Two branch instances share one stimulus stream: dut_a with a 16-bit
// counter and dut_b with a 2-bit counter. Stimulus tasks push the cycle in
// which each match pulse is due; a monitor pops and compares whenever a
// pulse is due or either instance raises one.
// ----------------------------------------------------------------------------
module tb_repeat_nfa_branch_param;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic [7:0] payload;
    logic       payload_valid;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [7:0] cfg_char;
    logic       cfg_rep;
    logic       cfg_len_we;
    logic [3:0] cfg_len;
    logic       cnt_clr;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    repeat_nfa_branch_param_if #(.COUNT_W(16), .IDX_W(3), .LEN_W(4)) ifa ();
    repeat_nfa_branch_param_if #(.COUNT_W(2),  .IDX_W(3), .LEN_W(4)) ifb ();

    assign ifa.en = en;               assign ifb.en = en;
    assign ifa.payload = payload;     assign ifb.payload = payload;
    assign ifa.payload_valid = payload_valid;
    assign ifb.payload_valid = payload_valid;
    assign ifa.cfg_we = cfg_we;       assign ifb.cfg_we = cfg_we;
    assign ifa.cfg_idx = cfg_idx;     assign ifb.cfg_idx = cfg_idx;
    assign ifa.cfg_char = cfg_char;   assign ifb.cfg_char = cfg_char;
    assign ifa.cfg_rep = cfg_rep;     assign ifb.cfg_rep = cfg_rep;
    assign ifa.cfg_len_we = cfg_len_we;
    assign ifb.cfg_len_we = cfg_len_we;
    assign ifa.cfg_len = cfg_len;     assign ifb.cfg_len = cfg_len;
    assign ifa.cnt_clr = cnt_clr;     assign ifb.cnt_clr = cnt_clr;

    repeat_nfa_branch_param #(.DEPTH(8), .COUNT_W(16), .IDX_W(3), .LEN_W(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.slave));
    repeat_nfa_branch_param #(.DEPTH(8), .COUNT_W(2), .IDX_W(3), .LEN_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        bit due;
        due = (exp_q.size() > 0) && (exp_q[0] == cyc);
        if (due) void'(exp_q.pop_front());
        if (ifa.match || due) check("match_a", {31'b0, ifa.match}, {31'b0, due});
        if (ifb.match || due) check("match_b", {31'b0, ifb.match}, {31'b0, due});
    end

    task automatic idle_inputs();
        payload_valid = 1'b0;
        cfg_we        = 1'b0;
        cfg_len_we    = 1'b0;
        cnt_clr       = 1'b0;
    endtask

    task automatic stall();
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic beat(input logic [7:0] ch, input bit hit, input bit e);
        @(posedge clk); #1;
        idle_inputs();
        en            = e;
        payload       = ch;
        payload_valid = 1'b1;
        if (hit) exp_q.push_back(cyc + 1);
    endtask

    // bit i of hits marks that char i completes the pattern
    task automatic stream(input string str, input logic [31:0] hits, input bit e);
        for (int i = 0; i < str.len(); i++) begin
            beat(str[i], hits[i], e);
        end
    endtask

    task automatic wr_char(input logic [2:0] idx, input logic [7:0] ch, input bit rep);
        @(posedge clk); #1;
        idle_inputs();
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_char = ch;
        cfg_rep  = rep;
    endtask

    task automatic wr_len(input logic [3:0] l);
        @(posedge clk); #1;
        idle_inputs();
        cfg_len_we = 1'b1;
        cfg_len    = l;
    endtask

    task automatic clr();
        @(posedge clk); #1;
        idle_inputs();
        cnt_clr = 1'b1;
    endtask

    task automatic check_cnt(input string name, input int exp);
        stall();
        stall();
        check({name, "_a"}, {16'b0, ifa.match_count}, exp);
        check({name, "_b"}, {30'b0, ifb.match_count}, (exp > 3) ? 3 : exp);
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_match"}, {30'b0, ifa.match, ifb.match}, 0);
        check({name, "_active"}, {30'b0, ifa.active, ifb.active}, 0);
        check({name, "_cnt_a"}, {16'b0, ifa.match_count}, 0);
        check({name, "_cnt_b"}, {30'b0, ifb.match_count}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        en = 1'b1; payload = 8'h00; cfg_idx = '0; cfg_char = 8'h00;
        cfg_rep = 1'b0; cfg_len = '0;
        idle_inputs();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #20;
        check_zero_outputs("reset");
        @(negedge clk) reset_n = 1'b1;

        // defaults "abc", start-anywhere
        stream("xabcx", 32'h8, 1'b1);
        check_cnt("cnt_basic", 1);

        // stall in the middle of the string
        beat("a", 1'b0, 1'b1);
        beat("b", 1'b0, 1'b1);
        stall();
        check("stall_active1", {31'b0, ifa.active}, 1);
        stall();
        check("stall_active2", {31'b0, ifa.active}, 1);
        beat("c", 1'b1, 1'b1);
        check_cnt("cnt_stall", 2);

        // back-to-back matches: 2-bit counter saturates and holds
        stream("abcabcabc", 32'h124, 1'b1);
        check_cnt("cnt_sat", 5);
        check_cnt("cnt_hold", 5);

        // clear in the very cycle a match pulse is high
        stream("abc", 32'h4, 1'b1);
        @(posedge clk); #1;
        idle_inputs();
        cnt_clr = 1'b1;
        check_cnt("cnt_clr_match", 0);

        // b+ in the middle
        wr_char(3'd1, "b", 1'b1);
        stream("abbbc", 32'h10, 1'b1);
        check_cnt("cnt_rep_mid", 1);
        wr_char(3'd1, "b", 1'b0);

        // c+ as final stage
        wr_char(3'd2, "c", 1'b1);
        wr_len(4'd3);
        clr();
        stream("abccc", 32'h1C, 1'b1);
        check_cnt("cnt_rep_last", 3);
        wr_char(3'd2, "c", 1'b0);

        // config write flushes a partial match
        beat("a", 1'b0, 1'b1);
        beat("b", 1'b0, 1'b1);
        wr_len(4'd3);
        stall();
        check("flush_active", {31'b0, ifa.active}, 0);
        beat("c", 1'b0, 1'b1);

        // length 0 disables the branch
        wr_len(4'd0);
        stream("abc", 32'h0, 1'b1);
        stall();
        check("len0_active", {31'b0, ifa.active}, 0);

        // length above DEPTH saturates to 8: "abc" + five 8'h00
        wr_len(4'd15);
        stream("abc", 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) beat(8'h00, (i == 4), 1'b1);
        wr_len(4'd3);

        // en low: no seed, but a string in progress continues
        stream("abc", 32'h0, 1'b0);
        beat("a", 1'b0, 1'b1);
        beat("b", 1'b0, 1'b0);
        beat("c", 1'b1, 1'b0);

        // character and length write in the same cycle
        @(posedge clk); #1;
        idle_inputs();
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_char = "z"; cfg_rep = 1'b0;
        cfg_len_we = 1'b1; cfg_len = 4'd1;
        beat("a", 1'b0, 1'b1);
        beat("z", 1'b1, 1'b1);

        // reset between 'b' and 'c' restores defaults and loses the string
        stall();
        beat("a", 1'b0, 1'b1);
        wr_char(3'd0, "a", 1'b0);
        wr_len(4'd3);
        beat("a", 1'b0, 1'b1);
        beat("b", 1'b0, 1'b1);
        stall();
        check("pre_reset_active", {31'b0, ifa.active}, 1);
        @(negedge clk) reset_n = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("hold_reset");
        @(negedge clk) reset_n = 1'b1;
        beat("c", 1'b0, 1'b1);
        stream("abc", 32'h4, 1'b1);
        check_cnt("cnt_after_reset", 1);

        repeat (4) stall();
        check("queue_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
